wb_commit_trace: RTL and testbench
==================================

// Module: wb_commit_trace
// PURPOSE
//  Downstream observer of the pipelined MIPS core `main`. Samples architectural commits each cycle:
//   - WB-stage register writes;
//   - MEM-stage data-memory writes.
//  Buffers them as timestamped records in a FIFO and drains them over a valid/ready port.
//  Replaces per-cycle $display dumping; the bench (or a later UART block) reads an ordered commit log.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of 2, >=4
//  TS_W       16  timestamp width; cycle counter wraps modulo 2**TS_W
//  POST_TRIG   4  commits captured after trigger PC seen, then capture freezes
// PORTS
//  clk        in   1   rising-edge clock, same as core
//  reset      in   1   asynchronous, active-low; all state cleared while low
//  enable     in   1   arm capture (level)
//  trig_en    in   1   enable PC trigger
//  trig_pc    in  32   trigger address, compared with PC_out
//  PC_out     in  32   core fetch PC
//  RegWriteWB in   1   WB register-write strobe
//  WriteRegister in 5  WB destination register
//  WriteData  in  32   WB write value
//  MemWriteMEM in  1   MEM store strobe
//  AddressMEM in  32   store address
//  StoreDataMEM in 32  store data
//  rec_valid  out  1   record available
//  rec_ready  in   1   consumer accepts when rec_valid&&rec_ready at clk edge
//  rec_kind   out  1   0=reg write, 1=mem write
//  rec_ts     out TS_W cycle stamp of commit
//  rec_addr   out 32   {27'b0,reg} or store address
//  rec_data   out 32   written value
//  state      out  2   FSM state
//  drop_cnt   out  8   records lost to full FIFO, saturates at 255
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, rec_valid=0, rec_* = 0, ts=0, drop_cnt=0, post counter=0.
//  Timestamp: free-running counter, +1 every clk in all states; a record carries the value at the sampling edge.
//  FSM (IDLE=0, RUN=1, POST=2, FROZEN=3):
//   IDLE -> RUN when enable=1.
//   RUN -> IDLE when enable=0.
//   RUN -> POST when trig_en && PC_out==trig_pc; post counter := POST_TRIG.
//   POST: each pushed record decrements the counter; at 0 -> FROZEN. enable=0 -> IDLE.
//   FROZEN: no capture; -> IDLE when enable=0 AND FIFO empty.
//  Capture is active only in RUN/POST.
//   Reg event: RegWriteWB && WriteRegister!=0; writes to $zero are never recorded.
//   Mem event: MemWriteMEM.
//  Both events in one cycle: push reg then mem (two entries, reg first).
//   If only one slot is free: reg pushed, mem dropped.
//   Each lost record: drop_cnt +1, saturating.
//  FIFO: DEPTH entries, ptrs log2(DEPTH)+1 bits. full = MSB differ and rest equal.
//  Latency: an event at edge N is visible on rec_* after edge N (rec_valid=1 in cycle N+1) if the FIFO was empty.
//  Output is show-ahead; rec_* hold stable while rec_valid && !rec_ready.
//  Push and pop in the same cycle when full: pop frees a slot for this edge's push; no drop.
//  enable deasserted mid-capture: already-buffered records remain readable; in-flight events that edge are still captured.
//  Async reset mid-operation discards FIFO contents immediately.
// STRUCTURE
//  Shared package (trace_pkg): state encodings, REC_REG/REC_MEM kind constants, record struct width (1+TS_W+64).
//  One sub-module: trace_fifo (2-write-port / 1-read-port synchronous FIFO with free-slot count).
//  FSM, timestamp, drop counter and event qualification live in the top.
// TESTING
//  1. reset low 2 cycles, release: rec_valid=0, state=0, drop_cnt=0, rec_ts=0.
//  2. enable=1; RegWriteWB=1, WriteRegister=16, WriteData=32'h5 at ts=7:
//     -> next cycle rec_valid=1, kind=0, addr=16, data=5, ts=7.
//  3. Same cycle reg($t0=8,32'hA) + store(addr 32'h40, data 32'hB):
//     -> two records in order reg then mem; a WriteRegister=0 strobe yields no record.
//  4. rec_ready=0, push DEPTH+3 single events -> FIFO holds DEPTH records, drop_cnt=3, rec_* stable.
//     Then rec_ready=1 -> DEPTH records drained in order.
//  5. trig_en=1, trig_pc=32'h20, POST_TRIG=4: PC_out hits 32'h20 -> state=2.
//     After 4 more records state=3; further commits ignored.
//     enable=0 with FIFO non-empty stays 3; drained -> 0.
//  6. Assert reset low while FIFO holds 5 records -> rec_valid falls immediately without a clock; drop_cnt=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace observer: FSM encodings, record kinds
// and record geometry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_e;

    localparam logic REC_REG = 1'b0;
    localparam logic REC_MEM = 1'b1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Record layout, MSB first: {kind, timestamp, address, data}.
    function automatic int rec_width(input int ts_w);
        return 1 + ts_w + ADDR_W + DATA_W;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with two ordered write ports, one show-ahead read port and a
// free-slot count that the producer uses to decide how many records fit.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 81
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_wr0_en,
    input  logic [W-1:0]                 i_wr0_data,
    input  logic                         i_wr1_en,
    input  logic [W-1:0]                 i_wr1_data,
    input  logic                         i_rd_en,
    output logic [W-1:0]                 o_rd_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_free
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] w_used;
    logic [PTR_W-1:0] w_wr1_ptr;
    logic [1:0]       w_wr_inc;
    logic             w_full;
    logic             w_rd_fire;

    assign w_used    = r_wr - r_rd;
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_empty   = (r_wr == r_rd);
    assign o_free    = w_full ? '0 : (PTR_W'(DEPTH) - w_used);
    assign w_wr1_ptr = r_wr + PTR_W'(1);
    assign w_wr_inc  = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
    assign w_rd_fire = i_rd_en && !o_empty;

    // Empty FIFO presents zeros so the consumer never sees stale storage.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    // NOTE: storage has no reset; validity is carried entirely by the pointers,
    // so clearing the pointers is enough and keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (i_wr0_en) r_mem[r_wr[AW-1:0]]      <= i_wr0_data;
        if (i_wr1_en) r_mem[w_wr1_ptr[AW-1:0]] <= i_wr1_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + PTR_W'(w_wr_inc);
            r_rd <= r_rd + PTR_W'(w_rd_fire);
        end
    end

endmodule

// File: rtl/wb_commit_trace.sv
// Commit observer for the pipelined MIPS core: timestamps WB register writes and
// MEM stores, buffers them in order and drains them over a valid/ready port.
module wb_commit_trace
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int POST_TRIG = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            trig_en,
    input  logic [31:0]     trig_pc,
    input  logic [31:0]     PC_out,
    input  logic            RegWriteWB,
    input  logic [4:0]      WriteRegister,
    input  logic [31:0]     WriteData,
    input  logic            MemWriteMEM,
    input  logic [31:0]     AddressMEM,
    input  logic [31:0]     StoreDataMEM,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic            rec_kind,
    output logic [TS_W-1:0] rec_ts,
    output logic [31:0]     rec_addr,
    output logic [31:0]     rec_data,
    output logic [1:0]      state,
    output logic [7:0]      drop_cnt
);

    localparam int REC_W   = rec_width(TS_W);
    localparam int PTR_W   = $clog2(DEPTH) + 1;
    localparam int PC_BITS = $clog2(POST_TRIG + 1);
    localparam int PC_W    = (PC_BITS < 2) ? 2 : PC_BITS;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [7:0]       r_drop;
    logic [PC_W-1:0]  r_post;
    logic [PC_W-1:0]  w_post_nxt;

    logic             w_capture;
    logic             w_reg_ev;
    logic             w_mem_ev;
    logic [REC_W-1:0] w_reg_rec;
    logic [REC_W-1:0] w_mem_rec;
    logic             w_wr0_en;
    logic             w_wr1_en;
    logic [REC_W-1:0] w_wr0_data;
    logic [REC_W-1:0] w_rd_data;
    logic             w_empty;
    logic             w_pop;
    logic [PTR_W-1:0] w_free;
    logic [PTR_W-1:0] w_room;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_drop;
    logic [8:0]       w_drop_sum;

    assign w_capture = (r_state == ST_RUN) || (r_state == ST_POST);
    assign w_reg_ev  = w_capture && RegWriteWB && (WriteRegister != 5'd0);
    assign w_mem_ev  = w_capture && MemWriteMEM;
    assign w_reg_rec = {REC_REG, r_ts, {27'b0, WriteRegister}, WriteData};
    assign w_mem_rec = {REC_MEM, r_ts, AddressMEM, StoreDataMEM};

    // A pop at this edge frees its slot for this edge's push, so a full FIFO
    // being drained does not drop.
    assign w_pop  = rec_valid && rec_ready;
    assign w_room = w_free + PTR_W'(w_pop);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_wr0_en   = 1'b0;
        w_wr1_en   = 1'b0;
        w_wr0_data = w_reg_rec;
        w_n_push   = 2'd0;
        w_n_drop   = 2'd0;
        if (w_reg_ev && w_mem_ev) begin
            if (w_room >= PTR_W'(2)) begin
                w_wr0_en = 1'b1;
                w_wr1_en = 1'b1;
                w_n_push = 2'd2;
            end else if (w_room == PTR_W'(1)) begin
                w_wr0_en = 1'b1;
                w_n_push = 2'd1;
                w_n_drop = 2'd1;
            end else begin
                w_n_drop = 2'd2;
            end
        end else if (w_reg_ev || w_mem_ev) begin
            w_wr0_data = w_reg_ev ? w_reg_rec : w_mem_rec;
            if (w_room != '0) begin
                w_wr0_en = 1'b1;
                w_n_push = 2'd1;
            end else begin
                w_n_drop = 2'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (trig_en && (PC_out == trig_pc)) begin
                    w_state_nxt = ST_POST;
                    w_post_nxt  = PC_W'(POST_TRIG);
                end
            end
            ST_POST: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_post_nxt  = '0;
                end else if (r_post <= PC_W'(w_n_push)) begin
                    w_state_nxt = ST_FROZEN;
                    w_post_nxt  = '0;
                end else begin
                    w_post_nxt = r_post - PC_W'(w_n_push);
                end
            end
            ST_FROZEN: begin
                if (!enable && w_empty) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop} + 9'(w_n_drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
            r_drop  <= '0;
            r_post  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= r_ts + TS_W'(1);
            r_drop  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_post  <= w_post_nxt;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr0_en   (w_wr0_en),
        .i_wr0_data (w_wr0_data),
        .i_wr1_en   (w_wr1_en),
        .i_wr1_data (w_mem_rec),
        .i_rd_en    (rec_ready),
        .o_rd_data  (w_rd_data),
        .o_empty    (w_empty),
        .o_free     (w_free)
    );

    assign rec_valid = !w_empty;
    assign {rec_kind, rec_ts, rec_addr, rec_data} = w_rd_data;
    assign state     = r_state;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Scoreboard bench for wb_commit_trace: directed commits push expected records,
// an independent monitor compares every accepted output record.
module tb_wb_commit_trace;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [31:0] PC_out;
    logic        RegWriteWB;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        MemWriteMEM;
    logic [31:0] AddressMEM;
    logic [31:0] StoreDataMEM;
    logic        rec_valid;
    logic        rec_ready;
    logic        rec_kind;
    logic [15:0] rec_ts;
    logic [31:0] rec_addr;
    logic [31:0] rec_data;
    logic [1:0]  state;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic        kind;
        logic [15:0] ts;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] cyc;

    wb_commit_trace #(.DEPTH(DEPTH), .TS_W(16), .POST_TRIG(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trig_en      (trig_en),
        .trig_pc      (trig_pc),
        .PC_out       (PC_out),
        .RegWriteWB   (RegWriteWB),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .MemWriteMEM  (MemWriteMEM),
        .AddressMEM   (AddressMEM),
        .StoreDataMEM (StoreDataMEM),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_kind     (rec_kind),
        .rec_ts       (rec_ts),
        .rec_addr     (rec_addr),
        .rec_data     (rec_data),
        .state        (state),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; cyc tracks the stamp
    // the DUT applies to commits presented in the current cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 16'd1;
    endtask

    task automatic ev(input bit r, input logic [4:0] rn, input logic [31:0] wd,
                      input bit m, input logic [31:0] a, input logic [31:0] sd,
                      input bit exp_r, input bit exp_m);
        exp_t e;
        RegWriteWB = r; WriteRegister = rn; WriteData = wd;
        MemWriteMEM = m; AddressMEM = a; StoreDataMEM = sd;
        if (exp_r) begin
            e.kind = 1'b0; e.ts = cyc; e.addr = {27'b0, rn}; e.data = wd;
            sb.push_back(e);
        end
        if (exp_m) begin
            e.kind = 1'b1; e.ts = cyc; e.addr = a; e.data = sd;
            sb.push_back(e);
        end
        step();
        RegWriteWB = 1'b0; MemWriteMEM = 1'b0; WriteRegister = 5'd0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = (sb.size() == 0) && !rec_valid;
        end
        check(name, {63'b0, done}, 64'd1);
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (reset && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rec: got addr %0h data %0h, required no record", rec_addr, rec_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rec_kind", {63'b0, rec_kind}, {63'b0, e.kind});
                check("rec_ts",   {48'b0, rec_ts},   {48'b0, e.ts});
                check("rec_addr", {32'b0, rec_addr}, {32'b0, e.addr});
                check("rec_data", {32'b0, rec_data}, {32'b0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; trig_en = 1'b0; trig_pc = 32'h0; PC_out = 32'h0;
        RegWriteWB = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
        MemWriteMEM = 1'b0; AddressMEM = 32'h0; StoreDataMEM = 32'h0;
        rec_ready = 1'b1; cyc = 16'd0;

        // 1. Reset for two cycles, then release.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc = 16'd0;
        check("reset_valid", {63'b0, rec_valid}, 64'd0);
        check("reset_state", {62'b0, state},     64'd0);
        check("reset_drop",  {56'b0, drop_cnt},  64'd0);
        check("reset_ts",    {48'b0, rec_ts},    64'd0);

        // 2. Single register write stamped 7.
        enable = 1'b1;
        repeat (7) step();
        check("run_state", {62'b0, state}, 64'd1);
        ev(1, 5'd16, 32'h5, 0, 32'h0, 32'h0, 1, 0);
        check("t2_valid", {63'b0, rec_valid}, 64'd1);
        check("t2_ts",    {48'b0, rec_ts},    64'd7);
        check("t2_addr",  {32'b0, rec_addr},  64'd16);
        check("t2_data",  {32'b0, rec_data},  64'd5);

        // 3. Register and store in one cycle, then a $zero write.
        ev(1, 5'd8, 32'hA, 1, 32'h40, 32'hB, 1, 1);
        check("t3_first_is_reg", {32'b0, rec_addr}, 64'd8);
        ev(1, 5'd0, 32'hDEAD, 0, 32'h0, 32'h0, 0, 0);
        wait_drain("t3_drain");

        // 4. Overfill with the consumer stalled.
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++)
            ev(1, 5'(i % 31 + 1), 32'h100 + 32'(i), 0, 32'h0, 32'h0, i < DEPTH, 0);
        check("t4_drop",      {56'b0, drop_cnt}, 64'd3);
        check("t4_head_addr", {32'b0, rec_addr}, 64'd1);
        repeat (3) step();
        check("t4_hold_addr", {32'b0, rec_addr}, 64'd1);
        check("t4_hold_data", {32'b0, rec_data}, 64'h100);
        // Full FIFO with a pop and a push at the same edge: nothing lost.
        rec_ready = 1'b1;
        ev(1, 5'd30, 32'h777, 0, 32'h0, 32'h0, 1, 0);
        check("t4_no_drop", {56'b0, drop_cnt}, 64'd3);
        wait_drain("t4_drain");

        // 5. PC trigger, post-trigger window, freeze, release.
        trig_en = 1'b1; trig_pc = 32'h20; PC_out = 32'h20;
        step();
        PC_out = 32'h0;
        check("t5_post", {62'b0, state}, 64'd2);
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            ev(0, 5'd0, 32'h0, 1, 32'h80 + 32'(4 * i), 32'h900 + 32'(i), 0, 1);
        check("t5_still_post", {62'b0, state}, 64'd2);
        ev(1, 5'd9, 32'h999, 0, 32'h0, 32'h0, 1, 0);
        check("t5_frozen", {62'b0, state}, 64'd3);
        ev(1, 5'd10, 32'hBAD, 1, 32'h44, 32'hBAD, 0, 0);
        enable = 1'b0;
        step();
        check("t5_frozen_nonempty", {62'b0, state}, 64'd3);
        rec_ready = 1'b1;
        wait_drain("t5_drain");
        step();
        check("t5_idle", {62'b0, state}, 64'd0);
        trig_en = 1'b0;

        // 6. Asynchronous reset with buffered records (drop_cnt is 3 here).
        enable = 1'b1;
        rec_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++)
            ev(1, 5'd5, 32'h50 + 32'(i), 0, 32'h0, 32'h0, 0, 0);
        check("t6_valid_before", {63'b0, rec_valid}, 64'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t6_valid_async", {63'b0, rec_valid}, 64'd0);
        check("t6_drop_async",  {56'b0, drop_cnt},  64'd0);
        check("t6_state_async", {62'b0, state},     64'd0);
        sb.delete();
        #10 reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
